mult_controller: RTL and testbench
==================================

Name: mult_controller

Overview:
Sequences the 32x32 unsigned multiplier datapath for MULT/MULTU instructions and owns the architectural HI/LO registers. Accepts a start request from the execute stage and converts signed operands to magnitudes. Holds the multiplier inputs stable for a fixed latency, then sign-corrects the 64-bit product and writes HI/LO. Also services MTHI/MTLO writes and stalls MFHI/MFLO reads while a multiply is in flight.

Parameters:
MULT_LATENCY, 4, clock cycles from stable multiplier inputs to valid mul_out (legal range 1..15).
CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MULT_LATENCY.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE or WB
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU
op_a  input  32  multiplicand
op_b  input  32  multiplier
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wr_data  input  32  data for MTHI/MTLO
hilo_rd  input  1  MFHI/MFLO read request from decode
mul_in1  output  32  operand magnitude to multiplier, registered
mul_in2  output  32  operand magnitude to multiplier, registered
mul_out  input  64  unsigned product returned by multiplier
hi  output  32  HI register
lo  output  32  LO register
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; HI/LO hold the new product this cycle
stall  output  1  combinational: hilo_rd && busy

Behaviour:
- Reset, synchronous and dominant over all inputs: state=IDLE; hi, lo, mul_in1, mul_in2, counter = 0; neg_flag = 0; busy = 0; done = 0. A reset mid-RUN abandons the multiply with no HI/LO update.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: count cycles; when counter == MULT_LATENCY-1 -> WB.
  - WB: one cycle, done=1. start=1 -> RUN (back-to-back); otherwise -> IDLE.
- Accept edge (IDLE/WB with start=1):
  - mul_in1 <= (is_signed && op_a[31]) ? -op_a : op_a, taken modulo 2^32, so 0x80000000 maps to 0x80000000.
  - mul_in2 is formed the same way from op_b.
  - neg_flag <= is_signed && (op_a[31] ^ op_b[31]).
  - counter <= 0.
- RUN: counter increments each edge. mul_in1 and mul_in2 are held constant for the whole of RUN.
- RUN->WB edge:
  - {hi,lo} <= neg_flag ? (~mul_out + 1) : mul_out, as a 64-bit result.
  - done <= 1.
  - The edge falls MULT_LATENCY edges after the accept edge, so done is high in cycle MULT_LATENCY+1, counting the cycle start was asserted as cycle 0.
- start is ignored (no queueing) while in RUN; the requester must observe busy.
- hi_we/lo_we:
  - Write hi/lo in IDLE and WB.
  - Dropped in RUN; the pipeline guarantees they never occur in RUN, and the bench asserts this.
  - hi_we or lo_we together with start in the same IDLE cycle: the write lands, then the product overwrites it at WB.
- stall = hilo_rd && busy. No stall in WB, because HI/LO are already updated there.
- done is high for exactly one cycle per completed multiply, including back-to-back WB->RUN->WB sequences.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_WB=2'd2), the 64-bit product width, and the 32-bit word width.
- One natural sub-module: mult_sign_fix, a combinational 32-bit conditional negate used for the operand magnitudes and reused as a 64-bit conditional negate for the product (parameterised on width).
- The FSM, counter and HI/LO registers stay in mult_controller.
- The multiplier datapath is instantiated alongside the controller, not inside it.

Test Plan:
1. Unsigned max: start, is_signed=0, op_a=op_b=0xFFFFFFFF -> done in cycle 5 (MULT_LATENCY=4); hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 1-4.
2. Signed mixed sign: op_a=0xFFFFFFFD (-3), op_b=5, is_signed=1 -> mul_in1=3, mul_in2=5; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
3. Signed corner: op_a=op_b=0x80000000, is_signed=1 -> mul_in1=mul_in2=0x80000000; hi=0x40000000, lo=0x00000000. Then op_a=0x80000000, op_b=1 -> hi=0xFFFFFFFF, lo=0x80000000.
4. Back-to-back: second start asserted in the WB cycle -> second done exactly 5 cycles after the first; each done is a single-cycle pulse; hi/lo hold the second product.
5. Stall/MTHI: hilo_rd held from cycle 1 -> stall=1 in cycles 1-4 and 0 in cycle 5. hi_we with wr_data=0x12345678 in IDLE -> hi=0x12345678 next cycle, lo unchanged.
6. Reset mid-operation: assert reset in cycle 2 of RUN -> next cycle state=IDLE, busy=0, hi=lo=0; no done pulse at the original completion cycle; a new start afterwards completes normally.

Source files
------------

// File: rtl/mult_controller_pkg.sv
// Shared definitions for the multiply controller: state encoding and datapath widths.
package mult_controller_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/mult_controller_if.sv
// Bundles the execute-stage request, HI/LO access and multiplier datapath signals.
interface mult_controller_if;
    import mult_controller_pkg::*;

    logic              start;
    logic              is_signed;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              hi_we;
    logic              lo_we;
    logic [WORD_W-1:0] wr_data;
    logic              hilo_rd;
    logic [WORD_W-1:0] mul_in1;
    logic [WORD_W-1:0] mul_in2;
    logic [PROD_W-1:0] mul_out;
    logic [WORD_W-1:0] hi;
    logic [WORD_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              stall;

    // Controller side.
    modport slave (
        input  start, is_signed, op_a, op_b, hi_we, lo_we, wr_data, hilo_rd, mul_out,
        output mul_in1, mul_in2, hi, lo, busy, done, stall
    );

    // Pipeline / multiplier side.
    modport master (
        output start, is_signed, op_a, op_b, hi_we, lo_we, wr_data, hilo_rd, mul_out,
        input  mul_in1, mul_in2, hi, lo, busy, done, stall
    );

endinterface

// File: rtl/mult_sign_fix.sv
// Combinational conditional two's-complement negate, width-parameterised.
module mult_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    // Negation wraps modulo 2^WIDTH, so the most negative value maps to itself.
    always_comb begin
        result = negate ? (~value + WIDTH'(1)) : value;
    end

endmodule

// File: rtl/mult_controller.sv
// Sequences an external unsigned multiplier for MULT/MULTU and owns HI/LO.
module mult_controller
    import mult_controller_pkg::*;
#(
    parameter int unsigned MULT_LATENCY = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    mult_controller_if.slave  bus
);

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(MULT_LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic              neg_flag_q;
    logic [WORD_W-1:0] mul_in1_q, mul_in2_q;
    logic [WORD_W-1:0] hi_q, lo_q;
    logic              accept;
    logic              finish;
    logic [WORD_W-1:0] mag_a, mag_b;
    logic [PROD_W-1:0] product;

    mult_sign_fix #(.WIDTH(WORD_W)) u_fix_a (
        .value  (bus.op_a),
        .negate (bus.is_signed && bus.op_a[WORD_W-1]),
        .result (mag_a)
    );

    mult_sign_fix #(.WIDTH(WORD_W)) u_fix_b (
        .value  (bus.op_b),
        .negate (bus.is_signed && bus.op_b[WORD_W-1]),
        .result (mag_b)
    );

    mult_sign_fix #(.WIDTH(PROD_W)) u_fix_prod (
        .value  (bus.mul_out),
        .negate (neg_flag_q),
        .result (product)
    );

    // Next-state logic; start is only honoured in IDLE and WB.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_d   = ST_RUN;
                    counter_d = '0;
                end
            end
            ST_RUN: begin
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == LastCount) begin
                    finish  = 1'b1;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_d   = ST_RUN;
                    counter_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Operand magnitudes and product sign, captured on accept and held through RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_in1_q  <= '0;
            mul_in2_q  <= '0;
            neg_flag_q <= 1'b0;
        end else if (accept) begin
            mul_in1_q  <= mag_a;
            mul_in2_q  <= mag_b;
            neg_flag_q <= bus.is_signed && (bus.op_a[WORD_W-1] ^ bus.op_b[WORD_W-1]);
        end
    end

    // HI/LO: product at RUN->WB; MTHI/MTLO outside RUN (a write alongside start is
    // later overwritten by the product).
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (finish) begin
            hi_q <= product[PROD_W-1:WORD_W];
            lo_q <= product[WORD_W-1:0];
        end else if (state_q != ST_RUN) begin
            if (bus.hi_we) begin
                hi_q <= bus.wr_data;
            end
            if (bus.lo_we) begin
                lo_q <= bus.wr_data;
            end
        end
    end

    assign bus.mul_in1 = mul_in1_q;
    assign bus.mul_in2 = mul_in2_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.busy    = (state_q == ST_RUN);
    assign bus.done    = (state_q == ST_WB);
    assign bus.stall   = bus.hilo_rd && bus.busy;

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller with a pipelined multiplier model.
module tb_mult_controller;

    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    mult_controller_if bus();

    mult_controller #(.MULT_LATENCY(LAT), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: product valid LAT cycles after its inputs become stable.
    logic [63:0] p0 = '0, p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p0 <= {32'b0, bus.mul_in1} * {32'b0, bus.mul_in2};
        p1 <= p0;
        p2 <= p1;
    end
    assign bus.mul_out = p2;

    // The pipeline must never issue MTHI/MTLO while a multiply runs.
    always @(posedge clk) begin
        if (bus.busy && (bus.hi_we || bus.lo_we)) begin
            n_bad++;
            $display("FAIL hilo_we_in_run: write enable seen while busy");
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [31:0] ref_mag(input logic [31:0] x, input logic s);
        return (s && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Issue start in the current cycle (cycle 0), then count cycles until done.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.op_a      = a;
        bus.op_b      = b;
        tick();
        bus.start     = 1'b0;
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
        bus.is_signed = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.done && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    // Full multiply with per-cycle checks of busy and held operands.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] in1, input logic [31:0] in2,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        launch(a, b, s);
        cyc = 1;
        while (!bus.done && cyc < 30) begin
            check({tag, "_busy"}, 64'(bus.busy), 64'(cyc <= LAT));
            check({tag, "_in1"}, 64'(bus.mul_in1), 64'(in1));
            check({tag, "_in2"}, 64'(bus.mul_in2), 64'(in2));
            tick();
            cyc++;
        end
        check({tag, "_done_cycle"}, 64'(cyc), 64'(LAT + 1));
        check({tag, "_wb_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_hilo"}, {bus.hi, bus.lo}, {ehi, elo});
        tick();
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int c1, c2, late_done;
        logic [31:0] ra, rb;
        logic        rs;
        logic [63:0] rp;

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 32'h00000003, 32'h00000005,
                    32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h00000000};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h80000000, 32'h00000001,
                    32'hFFFFFFFF, 32'h80000000};
        vecs[4] = '{32'h00000007, 32'hFFFFFFFF, 1'b0, 32'h00000007, 32'hFFFFFFFF,
                    32'h00000006, 32'hFFFFFFF9};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'h00000001,
                    32'h00000000, 32'h00000001};
        vecs[6] = '{32'h00000000, 32'hFFFFFFFE, 1'b1, 32'h00000000, 32'h00000002,
                    32'h00000000, 32'h00000000};

        reset = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0; bus.hilo_rd = 1'b0;
        tick();
        bus.start = 1'b1;   // reset must dominate start
        tick();
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_mul_in", {bus.mul_in1, bus.mul_in2}, 64'd0);
        bus.start = 1'b0;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                   vecs[i].in1, vecs[i].in2, vecs[i].hi, vecs[i].lo);
        end

        // Back-to-back: second start in the WB cycle.
        launch(32'd100, 32'd200, 1'b0);
        wait_done(c1);
        check("b2b_first_cycle", 64'(c1), 64'(LAT + 1));
        check("b2b_first_hilo", {bus.hi, bus.lo}, 64'd20000);
        launch(32'hFFFFFFF6, 32'd7, 1'b1);
        check("b2b_pulse_low", 64'(bus.done), 64'd0);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        wait_done(c2);
        check("b2b_second_gap", 64'(c2), 64'(LAT + 1));
        check("b2b_second_hilo", {bus.hi, bus.lo}, ref_prod(32'hFFFFFFF6, 32'd7, 1'b1));
        tick();
        check("b2b_second_pulse", 64'(bus.done), 64'd0);

        // Stall while busy, released in WB.
        launch(32'd9, 32'd9, 1'b0);
        bus.hilo_rd = 1'b1;
        for (int c = 1; c <= LAT + 1; c++) begin
            #1;
            check($sformatf("stall_c%0d", c), 64'(bus.stall), 64'(c <= LAT));
            if (c <= LAT) tick();
        end
        check("stall_wb_done", 64'(bus.done), 64'd1);
        bus.hilo_rd = 1'b0;
        tick();

        // MTHI / MTLO in IDLE.
        bus.hi_we = 1'b1; bus.wr_data = 32'h12345678;
        tick();
        bus.hi_we = 1'b0;
        check("mthi_hilo", {bus.hi, bus.lo}, {32'h12345678, 32'd81});
        bus.lo_we = 1'b1; bus.wr_data = 32'h0BADF00D;
        tick();
        bus.lo_we = 1'b0;
        check("mtlo_hilo", {bus.hi, bus.lo}, {32'h12345678, 32'h0BADF00D});

        // MTHI together with start: write lands, product later overwrites.
        bus.hi_we = 1'b1; bus.wr_data = 32'hCAFEF00D;
        launch(32'd3, 32'd4, 1'b0);
        bus.hi_we = 1'b0;
        check("mthi_start_hi", 64'(bus.hi), 64'h0000_0000_CAFE_F00D);
        wait_done(c1);
        check("mthi_start_hilo", {bus.hi, bus.lo}, 64'd12);
        tick();
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h55AA55AA;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;

        // Reset during the second RUN cycle abandons the multiply.
        launch(32'd5, 32'd6, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_mid_done", 64'(bus.done), 64'd0);
        late_done = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.done) late_done++;
        end
        check("rst_mid_no_done", 64'(late_done), 64'd0);
        check("rst_mid_hilo_after", {bus.hi, bus.lo}, 64'd0);
        do_mul("rst_recover", 32'd5, 32'd6, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30);

        // Randomised operands against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (i % 5 == 0) ra[31] = 1'b1;
            if (i % 7 == 0) rb[31] = 1'b1;
            rp = ref_prod(ra, rb, rs);
            do_mul($sformatf("rand%0d", i), ra, rb, rs, ref_mag(ra, rs), ref_mag(rb, rs),
                   rp[63:32], rp[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
